// File: rtl/alu_pkg.sv
// Shared ALU op codes and RV32I field encodings used by the decoder and the ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef struct packed {
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        illegal;
   } dec_entry_t;

   localparam int unsigned DEC_ENTRY_W = $bits(dec_entry_t);

   // funct3 to op for the funct7=0 / immediate forms (shift variants refined by caller)
   function automatic alu_op_t f3_base_op(input logic [2:0] f3);
      alu_op_t op;
      op = ALU_ADD;
      case (f3)
         F3_ADD_SUB: op = ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SR:      op = ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// One valid/ready register stage with an optional one-entry skid slot and synchronous flush.
module rv_skid_buffer #(
   parameter int unsigned W    = 8,
   parameter int unsigned SKID = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_out_valid;
   logic         r_skid_valid;
   logic [W-1:0] r_out_data;
   logic [W-1:0] r_skid_data;
   logic         w_in_fire;
   logic         w_out_free;

   // in_ready held low during reset; with the skid slot it depends only on registered state
   always_comb begin
      if (SKID != 0) o_ready = rst_n & ~r_skid_valid;
      else           o_ready = rst_n & (~r_out_valid | i_ready);
   end

   assign w_in_fire  = i_valid & o_ready;
   assign w_out_free = ~r_out_valid | i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out_data   <= '0;
         r_skid_data  <= '0;
      end else if (i_flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
         // a held skid entry is older than anything on the input, so it drains first
         if (r_skid_valid) begin
            r_out_data   <= r_skid_data;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else begin
            r_out_valid <= w_in_fire;
            if (w_in_fire) r_out_data <= i_data;
         end
      end else if (w_in_fire) begin
         r_skid_data  <= i_data;
         r_skid_valid <= 1'b1;
      end
   end

   assign o_valid = r_out_valid;
   assign o_data  = r_out_data;

endmodule

// File: rtl/alu_op_decoder.sv
// Decodes RV32I OP/OP-IMM/LUI/AUIPC into ALU op and operands, registered through a skid stage.
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SKID = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_op,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   if (XLEN != 32) begin : g_xlen_chk
      $error("alu_op_decoder supports XLEN=32 only");
   end

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i;
   logic [31:0] w_shamt;
   logic [31:0] w_imm_u;
   logic        w_ok;
   dec_entry_t  w_dec;
   dec_entry_t  w_out;

   assign w_opcode = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_f7     = in_instr[31:25];
   assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign w_shamt  = {27'b0, in_instr[24:20]};
   assign w_imm_u  = {in_instr[31:12], 12'b0};

   always_comb begin
      w_dec    = '0;
      w_dec.op = ALU_ADD;
      w_dec.rd = in_instr[11:7];
      w_ok     = 1'b1;
      case (w_opcode)
         OPC_OP: begin
            w_dec.a = in_rs1_val;
            w_dec.b = in_rs2_val;
            if (w_f7 == F7_BASE)                          w_dec.op = f3_base_op(w_f3);
            else if (w_f7 == F7_ALT && w_f3 == F3_ADD_SUB) w_dec.op = ALU_SUB;
            else if (w_f7 == F7_ALT && w_f3 == F3_SR)      w_dec.op = ALU_SRA;
            else                                           w_ok     = 1'b0;
         end
         OPC_OP_IMM: begin
            w_dec.a  = in_rs1_val;
            w_dec.b  = w_imm_i;
            w_dec.op = f3_base_op(w_f3);
            // imm[11:5] doubles as the funct7 qualifier for shift-immediates
            if (w_f3 == F3_SLL) begin
               w_dec.b = w_shamt;
               w_ok    = (w_f7 == F7_BASE);
            end else if (w_f3 == F3_SR) begin
               w_dec.b = w_shamt;
               if (w_f7 == F7_ALT)       w_dec.op = ALU_SRA;
               else if (w_f7 != F7_BASE) w_ok     = 1'b0;
            end
         end
         OPC_LUI: begin
            w_dec.b = w_imm_u;
         end
         OPC_AUIPC: begin
            w_dec.a = in_pc;
            w_dec.b = w_imm_u;
         end
         default: w_ok = 1'b0;
      endcase
      if (!w_ok) begin
         w_dec         = '0;
         w_dec.op      = ALU_ADD;
         w_dec.illegal = 1'b1;
      end
   end

   rv_skid_buffer #(
      .W    (DEC_ENTRY_W),
      .SKID (SKID)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_dec),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_out)
   );

   assign out_op      = w_out.op;
   assign out_a       = w_out.a;
   assign out_b       = w_out.b;
   assign out_rd      = w_out.rd;
   assign out_illegal = w_out.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench: directed literal cases plus random traffic against a queue-based model.
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_rs1_val = '0;
   logic [31:0] in_rs2_val = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_op;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   // ADD SLL SLT SLTU XOR SRL OR AND, indexed by funct3
   localparam int OPF3 [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

   exp_t q[$];

   alu_op_decoder #(.XLEN(32), .SKID(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_val  (in_rs1_val),
      .in_rs2_val  (in_rs2_val),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_op      (out_op),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model_decode(input logic [31:0] instr, input logic [31:0] pc,
                                         input logic [31:0] rs1, input logic [31:0] rs2);
      exp_t e;
      int unsigned opc, f3, f7;
      opc   = instr & 32'h7F;
      f3    = (instr >> 12) & 32'h7;
      f7    = instr >> 25;
      e.op  = 4'd0;
      e.a   = '0;
      e.b   = '0;
      e.rd  = 5'((instr >> 7) & 32'h1F);
      e.ill = 1'b1;
      if (opc == 32'h33) begin
         e.a = rs1;
         e.b = rs2;
         if (f7 == 0)                    begin e.op = 4'(OPF3[f3]); e.ill = 1'b0; end
         else if (f7 == 32 && f3 == 0)   begin e.op = 4'd1;         e.ill = 1'b0; end
         else if (f7 == 32 && f3 == 5)   begin e.op = 4'd9;         e.ill = 1'b0; end
      end else if (opc == 32'h13) begin
         e.a   = rs1;
         e.b   = 32'($signed(instr) >>> 20);
         e.op  = 4'(OPF3[f3]);
         e.ill = 1'b0;
         if (f3 == 1 || f3 == 5) begin
            e.b = (instr >> 20) & 32'h1F;
            if (f3 == 5 && f7 == 32) e.op  = 4'd9;
            else if (f7 != 0)        e.ill = 1'b1;
         end
      end else if (opc == 32'h37) begin
         e.b   = instr & 32'hFFFFF000;
         e.ill = 1'b0;
      end else if (opc == 32'h17) begin
         e.a   = pc;
         e.b   = instr & 32'hFFFFF000;
         e.ill = 1'b0;
      end
      if (e.ill) begin
         e.op = 4'd0;
         e.a  = '0;
         e.b  = '0;
         e.rd = '0;
      end
      return e;
   endfunction

   // Model: in-order queue holding at most two entries (output register + skid)
   always @(posedge clk or negedge rst_n) begin
      bit acc;
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         acc = in_valid && (q.size() < 2);
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (acc) q.push_back(model_decode(in_instr, in_pc, in_rs1_val, in_rs2_val));
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_in_ready", 32'(in_ready), 0);
         chk("rst_data", {out_a ^ out_b, 32'(out_op) | 32'(out_rd) | 32'(out_illegal)} == 64'd0 ? 1 : 0, 1);
      end else begin
         chk("cmp_out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("cmp_in_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() != 0) begin
            chk("cmp_op", 32'(out_op), 32'(q[0].op));
            chk("cmp_a", out_a, q[0].a);
            chk("cmp_b", out_b, q[0].b);
            chk("cmp_rd", 32'(out_rd), 32'(q[0].rd));
            chk("cmp_illegal", 32'(out_illegal), 32'(q[0].ill));
         end
      end
   end

   task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid   = 1'b1;
      in_instr   = instr;
      in_pc      = pc;
      in_rs1_val = rs1;
      in_rs2_val = rs2;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 5))
         0:       w[6:0] = 7'h33;
         1, 2:    w[6:0] = 7'h13;
         3:       w[6:0] = 7'h37;
         4:       w[6:0] = 7'h17;
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0:       w[31:25] = 7'h00;
         1:       w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      exp_t m;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_in_ready", 32'(in_ready), 0);
      chk("reset_out_b", out_b, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("post_reset_in_ready", 32'(in_ready), 1);
      step();
      out_ready = 1'b1;

      // model pinned by hand-computed values
      m = model_decode(32'hFFD08293, 0, 10, 0);
      chk("model_addi_b", m.b, 32'hFFFFFFFD);
      m = model_decode(32'h40415193, 0, 1, 0);
      chk("model_srai_op", 32'(m.op), 9);

      send(32'hFFD08293, 0, 10, 0);
      chk("addi_valid", 32'(out_valid), 1);
      chk("addi_op", 32'(out_op), 0);
      chk("addi_a", out_a, 10);
      chk("addi_b", out_b, 32'hFFFFFFFD);
      chk("addi_rd", 32'(out_rd), 5);
      chk("addi_illegal", 32'(out_illegal), 0);

      send(32'h40415193, 0, 32'h80000000, 0);
      chk("srai_op", 32'(out_op), 9);
      chk("srai_b", out_b, 4);
      chk("srai_rd", 32'(out_rd), 3);
      send(32'h60415193, 0, 7, 0);
      chk("bad_srai_illegal", 32'(out_illegal), 1);
      chk("bad_srai_a", out_a, 0);
      chk("bad_srai_rd", 32'(out_rd), 0);

      send(32'h123452B7, 32'h200, 9, 9);
      chk("lui_a", out_a, 0);
      chk("lui_b", out_b, 32'h12345000);
      send(32'h12345297, 32'h100, 9, 9);
      chk("auipc_a", out_a, 32'h100);
      chk("auipc_b", out_b, 32'h12345000);
      step();
      chk("idle_valid", 32'(out_valid), 0);

      // stall: SUB fills output, XOR goes to skid
      out_ready = 1'b0;
      send(32'h403100B3, 0, 20, 7);
      chk("stall_in_ready_1", 32'(in_ready), 1);
      send(32'h0062C233, 0, 32'hF0F0, 32'h0FF0);
      chk("stall_in_ready_2", 32'(in_ready), 0);
      step();
      chk("stall_hold_op", 32'(out_op), 1);
      chk("stall_hold_a", out_a, 20);
      out_ready = 1'b1;
      step();
      chk("drain_xor_op", 32'(out_op), 4);
      chk("drain_xor_rd", 32'(out_rd), 4);
      chk("drain_in_ready", 32'(in_ready), 1);
      step();
      chk("drain_empty", 32'(out_valid), 0);

      // flush with both slots full and a simultaneous input offer
      out_ready = 1'b0;
      send(32'h403100B3, 0, 1, 2);
      send(32'h0062C233, 0, 3, 4);
      flush      = 1'b1;
      in_valid   = 1'b1;
      in_instr   = 32'hFFD08293;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      out_ready = 1'b1;
      repeat (3) step();
      chk("flush_nothing_emitted", 32'(out_valid), 0);

      // asynchronous reset with two entries held
      out_ready = 1'b0;
      send(32'h403100B3, 0, 5, 6);
      send(32'h0062C233, 0, 7, 8);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_out_a", out_a, 0);
      chk("midrst_out_b", out_b, 0);
      chk("midrst_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      for (int i = 0; i < 3000; i++) begin
         in_valid   = ($urandom_range(0, 9) < 7);
         out_ready  = ($urandom_range(0, 9) < 7);
         flush      = ($urandom_range(0, 99) < 3);
         in_instr   = rand_instr();
         in_pc      = $urandom;
         in_rs1_val = $urandom;
         in_rs2_val = $urandom;
         rst_n      = (i != 1500);
         step();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
